// File: rtl/udm_bus_mux_pkg.sv
// Shared udm bus widths, address/data types and the slave address-decode helper.
// Pure definitions; no logic, no latency, no flow control.
package udm_bus_mux_pkg;

    localparam int UDM_ADDR_W = 32;
    localparam int UDM_DATA_W = 32;
    localparam int UDM_BE_W   = 4;

    typedef logic [UDM_ADDR_W-1:0] udm_addr_t;
    typedef logic [UDM_DATA_W-1:0] udm_data_t;

    function automatic logic slave_hit(input udm_addr_t addr, input udm_addr_t base, input udm_addr_t mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/udm_bus_mux_ordfifo.sv
// Read-order FIFO of target indices; head visible combinationally, push/pop take effect at the clock edge.
// Pushes while full and pops while empty are ignored; the caller stalls on full_o.
module udm_bus_mux_ordfifo #(
    parameter int DEPTH_POW = 2,
    parameter int ENTRY_W   = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_dat_i,
    input  logic               pop_i,
    output logic               full_o,
    output logic               empty_o,
    output logic [ENTRY_W-1:0] head_o
);

    localparam int DEPTH = 1 << DEPTH_POW;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [DEPTH_POW:0] r_wr_ptr;
    logic [DEPTH_POW:0] r_rd_ptr;
    logic               w_push;
    logic               w_pop;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign full_o  = (r_wr_ptr[DEPTH_POW] != r_rd_ptr[DEPTH_POW]) &&
                     (r_wr_ptr[DEPTH_POW-1:0] == r_rd_ptr[DEPTH_POW-1:0]);
    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign head_o  = r_mem[r_rd_ptr[DEPTH_POW-1:0]];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr[DEPTH_POW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/udm_bus_mux.sv
// Address-decoding udm fan-out; requests pass through combinationally, read data returns 1 cycle after the head slave responds.
// Reads stall while the order FIFO is full; unmapped writes are acked and dropped. UDM_BUS_MUX_ERRCNT_EN adds an unmapped-access counter.
module udm_bus_mux
    import udm_bus_mux_pkg::*;
#(
    parameter int                       NUM_SLAVES    = 4,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE    = {32'h80000000, 32'h00001000, 32'h00000004, 32'h00000000},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK    = {32'hFFFFF000, 32'hFFFFF000, 32'hFFFFFFFC, 32'hFFFFFFFC},
    parameter int                       ORD_DEPTH_POW = 2,
    parameter udm_data_t                ERR_RDATA     = 32'hDEADBEEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     m_req_i,
    input  logic                     m_we_i,
    input  udm_addr_t                m_addr_bi,
    input  logic [UDM_BE_W-1:0]      m_be_bi,
    input  udm_data_t                m_wdata_bi,
    output logic                     m_ack_o,
    output logic                     m_resp_o,
    output udm_data_t                m_rdata_bo,
    output logic [NUM_SLAVES-1:0]    s_req_bo,
    output logic                     s_we_o,
    output udm_addr_t                s_addr_bo,
    output logic [UDM_BE_W-1:0]      s_be_bo,
    output udm_data_t                s_wdata_bo,
    input  logic [NUM_SLAVES-1:0]    s_ack_bi,
    input  logic [NUM_SLAVES-1:0]    s_resp_bi,
    input  logic [NUM_SLAVES*32-1:0] s_rdata_bi
`ifdef UDM_BUS_MUX_ERRCNT_EN
    ,
    output logic [15:0]              err_cnt_bo,
    input  logic                     err_clr_i
`endif
);

    localparam int SEL_W = $clog2(NUM_SLAVES + 1);
    localparam logic [SEL_W-1:0] SEL_UNMAPPED = SEL_W'(NUM_SLAVES);

    logic             w_hit;
    logic [SEL_W-1:0] w_sel;
    logic             w_ack_sel;
    logic             w_full;
    logic             w_empty;
    logic             w_stall;
    logic             w_push;
    logic             w_pop;
    logic [SEL_W-1:0] w_head;
    logic             w_head_err;
    logic             w_head_resp;
    udm_data_t        w_head_rdata;
    logic             r_resp;
    udm_data_t        r_rdata;

    // Descending scan so the lowest matching index is the one left in w_sel.
    always_comb begin
        w_hit = 1'b0;
        w_sel = SEL_UNMAPPED;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (slave_hit(m_addr_bi, SLAVE_BASE[32*i +: 32], SLAVE_MASK[32*i +: 32])) begin
                w_hit = 1'b1;
                w_sel = SEL_W'(i);
            end
        end
    end

    always_comb begin
        w_ack_sel    = 1'b0;
        w_head_resp  = 1'b0;
        w_head_rdata = '0;
        s_req_bo     = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (w_sel == SEL_W'(i)) begin
                w_ack_sel   = s_ack_bi[i];
                s_req_bo[i] = m_req_i & w_hit & ~w_stall;
            end
            if (w_head == SEL_W'(i)) begin
                w_head_resp  = s_resp_bi[i];
                w_head_rdata = s_rdata_bi[32*i +: 32];
            end
        end
    end

    assign w_stall    = ~m_we_i & w_full;
    assign m_ack_o    = m_req_i & (w_hit ? (w_ack_sel & ~w_stall) : (m_we_i | ~w_full));
    assign w_push     = m_req_i & m_ack_o & ~m_we_i;
    assign w_head_err = (w_head == SEL_UNMAPPED);
    assign w_pop      = ~w_empty & (w_head_err | w_head_resp);

    assign s_we_o     = m_we_i;
    assign s_addr_bo  = m_addr_bi;
    assign s_be_bo    = m_be_bi;
    assign s_wdata_bo = m_wdata_bi;

    udm_bus_mux_ordfifo #(
        .DEPTH_POW (ORD_DEPTH_POW),
        .ENTRY_W   (SEL_W)
    ) u_ordfifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (w_push),
        .push_dat_i (w_sel),
        .pop_i      (w_pop),
        .full_o     (w_full),
        .empty_o    (w_empty),
        .head_o     (w_head)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resp  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_resp <= w_pop;
            if (w_pop) r_rdata <= w_head_err ? ERR_RDATA : w_head_rdata;
        end
    end

    assign m_resp_o   = r_resp;
    assign m_rdata_bo = r_rdata;

`ifdef UDM_BUS_MUX_ERRCNT_EN
    logic [15:0] r_err_cnt;
    logic        w_err_acc;

    assign w_err_acc = m_req_i & m_ack_o & ~w_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i || err_clr_i) begin
            r_err_cnt <= '0;
        end else if (w_err_acc && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt_bo = r_err_cnt;
`endif

endmodule
